// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the DAC ramp scheduler.
//   - Command op encodings as carried on req_op.
//   - Ramp FSM state encoding.
//   - Default DAC code and command amount widths.
//   - Saturating add/subtract helper used for target updates.
package dac_ctrl_pkg;

  localparam int unsigned DAC_W_DEF = 12;
  localparam int unsigned AMT_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_ON  = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_OFF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SEND  = 2'b01,
    ST_EMERG = 2'b10
  } state_e;

  // Clamps to [0, maxv]. Operands are zero-extended into 32 bits, wide
  // enough for DAC_W + AMT_SHIFT + 1 with the default widths.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] delta,
                                           input logic [31:0] maxv,
                                           input logic        dec);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, delta};
    if (dec) begin
      return (delta >= cur) ? '0 : (cur - delta);
    end
    return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
  endfunction

endpackage

// File: rtl/dac_ramp_scheduler_rr_arbiter.sv
// Round-robin arbiter with a priority-override mask.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_i       - per-requester request
//   prio_i      - per-requester override; any requesting override wins,
//                 lowest index first, and leaves the pointer untouched
//   grant_o     - one-hot combinational grant (zero when no request)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] prio_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  logic             prio_hit;
  logic [NUM_REQ-1:0] prio_req;

  assign prio_req = req_i & prio_i;
  assign prio_hit = |prio_req;

  // Round-robin search runs as two passes (indices at/after the pointer,
  // then the wrapped ones) so every select uses a constant index.
  always_comb begin
    grant_o = '0;
    win_idx = '0;
    found   = 1'b0;
    if (prio_hit) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && prio_req[i]) begin
          grant_o[i] = 1'b1;
          win_idx    = IDX_W'(i);
          found      = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (IDX_W'(i) >= ptr_q)) begin
          grant_o[i] = 1'b1;
          win_idx    = IDX_W'(i);
          found      = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (IDX_W'(i) < ptr_q)) begin
          grant_o[i] = 1'b1;
          win_idx    = IDX_W'(i);
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && !prio_hit) begin
      ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx + IDX_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dac_ramp_scheduler.sv
// Shares the ultrasonic drive DAC between NUM_REQ command sources.
// Commands (ON/INC/DEC/OFF) are arbitrated round-robin with OFF taking
// priority; the target is slewed toward in RAMP_STEP steps every
// UPDATE_DIV cycles; OFF forces an immediate write of 0.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_op/
//   req_amount/req_ready  - per-requester command handshake
//   dac_data/dac_valid/
//   dac_ready             - DAC word handshake
//   enabled, target,
//   level                 - output enable, target code, last delivered code
//   cmd_drop              - pulse when INC/DEC is ignored while disabled
//   busy                  - ramp in progress or word outstanding
module dac_ramp_scheduler
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DAC_W      = DAC_W_DEF,
  parameter int unsigned AMT_W      = AMT_W_DEF,
  parameter int unsigned AMT_SHIFT  = 4,
  parameter int unsigned RAMP_STEP  = 64,
  parameter int unsigned UPDATE_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [AMT_W*NUM_REQ-1:0] req_amount,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [DAC_W-1:0]         dac_data,
  output logic                     dac_valid,
  input  logic                     dac_ready,
  output logic                     enabled,
  output logic [DAC_W-1:0]         target,
  output logic [DAC_W-1:0]         level,
  output logic                     cmd_drop,
  output logic                     busy
);

  localparam int unsigned    CNT_W      = $clog2(UPDATE_DIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(UPDATE_DIV - 1);
  localparam logic [DAC_W-1:0] STEP       = DAC_W'(RAMP_STEP);
  localparam logic [31:0]      DAC_MAX32  = {{(32-DAC_W){1'b0}}, {DAC_W{1'b1}}};

  // ---------------- arbitration ----------------
  logic [NUM_REQ-1:0] off_mask;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  op_e                sel_op;
  logic [AMT_W-1:0]   sel_amt;

  always_comb begin
    off_mask = '0;
    sel_op   = OP_ON;
    sel_amt  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      off_mask[i] = (req_op[2*i +: 2] == OP_OFF);
      if (grant[i]) begin
        sel_op  = op_e'(req_op[2*i +: 2]);
        sel_amt = req_amount[AMT_W*i +: AMT_W];
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_valid),
    .prio_i (off_mask),
    .grant_o(grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // ---------------- command state ----------------
  logic             en_q, en_d;
  logic [DAC_W-1:0] tgt_q, tgt_d;
  logic             drop_q, drop_d;
  logic             pend_q, pend_d;
  logic             off_acc;
  logic             emerg_done;
  logic [31:0]      delta32;

  assign delta32 = 32'(sel_amt) << AMT_SHIFT;

  always_comb begin
    en_d    = en_q;
    tgt_d   = tgt_q;
    drop_d  = 1'b0;
    off_acc = 1'b0;
    if (accept) begin
      case (sel_op)
        OP_ON: en_d = 1'b1;
        OP_INC, OP_DEC: begin
          if (!en_q) begin
            drop_d = 1'b1;
          end else begin
            tgt_d = DAC_W'(sat_step(32'(tgt_q), delta32, DAC_MAX32, sel_op == OP_DEC));
          end
        end
        OP_OFF: begin
          en_d    = 1'b0;
          tgt_d   = '0;
          off_acc = 1'b1;
        end
        default: ;
      endcase
    end
    // A fresh OFF landing on the same edge as an emergency handshake keeps
    // the request pending so its own write of 0 still goes out.
    pend_d = (pend_q && !emerg_done) || off_acc;
  end

  // ---------------- update tick ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick  = (cnt_q == '0);
  assign cnt_d = tick ? CNT_RELOAD : (cnt_q - CNT_W'(1));

  // ---------------- ramp FSM ----------------
  state_e           state_q, state_d;
  logic [DAC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [DAC_W-1:0] lvl_q, lvl_d;
  logic [DAC_W-1:0] diff;
  logic [DAC_W-1:0] step;
  logic [DAC_W-1:0] ramp_next;

  always_comb begin
    if (tgt_q > lvl_q) begin
      diff      = tgt_q - lvl_q;
      step      = (diff > STEP) ? STEP : diff;
      ramp_next = lvl_q + step;
    end else begin
      diff      = lvl_q - tgt_q;
      step      = (diff > STEP) ? STEP : diff;
      ramp_next = lvl_q - step;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    lvl_d      = lvl_q;
    emerg_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_EMERG;
          data_d  = '0;
          valid_d = 1'b1;
        end else if (tick && (lvl_q != tgt_q)) begin
          state_d = ST_SEND;
          data_d  = ramp_next;
          valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (dac_ready) begin
          lvl_d   = data_q;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_EMERG: begin
        if (dac_ready) begin
          lvl_d      = '0;
          valid_d    = 1'b0;
          emerg_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      tgt_q   <= '0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= CNT_RELOAD;
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      lvl_q   <= '0;
    end else begin
      en_q    <= en_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lvl_q   <= lvl_d;
    end
  end

  assign dac_data  = data_q;
  assign dac_valid = valid_q;
  assign enabled   = en_q;
  assign target    = tgt_q;
  assign level     = lvl_q;
  assign cmd_drop  = drop_q;
  assign busy      = (lvl_q != tgt_q) || valid_q;

endmodule

// File: tb/tb_dac_ramp_scheduler.sv
module tb_dac_ramp_scheduler;
  import dac_ctrl_pkg::*;

  localparam int unsigned UDIV = 4;
  localparam int unsigned STEP = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [5:0]  req_op;
  logic [23:0] req_amount;
  logic [2:0]  req_ready;
  logic [11:0] dac_data;
  logic        dac_valid;
  logic        dac_ready;
  logic        enabled;
  logic [11:0] target;
  logic [11:0] level;
  logic        cmd_drop;
  logic        busy;

  dac_ramp_scheduler #(
    .NUM_REQ   (3),
    .DAC_W     (12),
    .AMT_W     (8),
    .AMT_SHIFT (4),
    .RAMP_STEP (STEP),
    .UPDATE_DIV(UDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_amount(req_amount),
    .req_ready (req_ready),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .enabled   (enabled),
    .target    (target),
    .level     (level),
    .cmd_drop  (cmd_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    bit          emerg;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 1'b1;
  int   gap     = 1000;

  // reference model state
  int   m_ptr = 0;
  int   m_tgt = 0;
  int   m_lvl = 0;

  // Scoreboard: every delivered word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) gap++;
    if (rst_n && dac_valid && dac_ready) begin
      if (sb_on) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL dac_word: got unexpected write %0d, required no write", dac_data);
        end else begin
          e = sb_q.pop_front();
          if (dac_data !== e.data) begin
            n_fail++;
            $display("FAIL dac_word: got %0d, required %0d", dac_data, e.data);
          end
          if (!e.emerg) begin
            n_tests++;
            if (gap < int'(UDIV)) begin
              n_fail++;
              $display("FAIL ramp_gap: got %0d cycles, required >= %0d", gap, UDIV);
            end
          end
        end
      end
      gap = 0;
    end
  end

  task automatic expect_ramp();
    exp_t e;
    int   d;
    while (m_lvl != m_tgt) begin
      d = (m_tgt > m_lvl) ? (m_tgt - m_lvl) : (m_lvl - m_tgt);
      if (d > int'(STEP)) d = STEP;
      m_lvl   = (m_tgt > m_lvl) ? (m_lvl + d) : (m_lvl - d);
      e.data  = 12'(m_lvl);
      e.emerg = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic expect_emerg();
    exp_t e;
    e.data  = '0;
    e.emerg = 1'b1;
    sb_q.push_back(e);
    m_lvl = 0;
  endtask

  // Entered and left at posedge+#1; the command effect is visible on return.
  task automatic send_cmd(input int r, input logic [1:0] op, input logic [7:0] amt);
    int c = 0;
    req_valid[r]        = 1'b1;
    req_op[2*r +: 2]    = op;
    req_amount[8*r +: 8] = amt;
    @(negedge clk);
    while (!req_ready[r] && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!req_ready[r]) begin
      n_fail++;
      $display("FAIL cmd_grant: req%0d ready=%0b, required 1 within 20 cycles", r, req_ready[r]);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    if (op != OP_OFF) m_ptr = (r + 1) % 3;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int c = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (busy || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%0b pending_words=%0d, required busy=0 pending=0",
               name, busy, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_enabled", int'(enabled), 0);
    check_val("rst_target", int'(target), 0);
    check_val("rst_level", int'(level), 0);
    check_val("rst_dac_valid", int'(dac_valid), 0);
    check_val("rst_dac_data", int'(dac_data), 0);
    check_val("rst_cmd_drop", int'(cmd_drop), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0; m_tgt = 0; m_lvl = 0;
  endtask

  task automatic test_ramp();
    send_cmd(0, OP_ON, 8'd0);
    check_val("on_enabled", int'(enabled), 1);
    check_val("on_target", int'(target), 0);
    send_cmd(0, OP_INC, 8'd10);
    m_tgt = 160;
    check_val("inc_target", int'(target), m_tgt);
    expect_ramp();
    wait_idle("ramp", 100);
    check_val("ramp_level", int'(level), 160);
    check_val("ramp_busy", int'(busy), 0);
  endtask

  task automatic test_saturate();
    send_cmd(1, OP_INC, 8'd240);
    m_tgt = 4000;
    check_val("sat_t4000", int'(target), m_tgt);
    expect_ramp();
    wait_idle("sat_up", 600);
    send_cmd(2, OP_INC, 8'd20);
    m_tgt = 4095;
    check_val("sat_inc_clamp", int'(target), m_tgt);
    expect_ramp();
    wait_idle("sat_top", 100);
    check_val("sat_level_top", int'(level), 4095);
    send_cmd(0, OP_DEC, 8'd255);
    m_tgt = 15;
    check_val("sat_dec_15", int'(target), m_tgt);
    expect_ramp();
    wait_idle("sat_down", 600);
    send_cmd(1, OP_DEC, 8'd255);
    m_tgt = 0;
    check_val("sat_dec_floor", int'(target), m_tgt);
    expect_ramp();
    wait_idle("sat_floor", 100);
    check_val("sat_level_0", int'(level), 0);
  endtask

  task automatic test_disabled_drop();
    int vcount = 0;
    send_cmd(1, OP_OFF, 8'd0);
    m_tgt = 0;
    check_val("off_enabled", int'(enabled), 0);
    expect_emerg();
    wait_idle("off", 20);
    send_cmd(0, OP_INC, 8'd5);
    check_val("drop_pulse", int'(cmd_drop), 1);
    check_val("drop_target", int'(target), 0);
    @(posedge clk);
    #1;
    check_val("drop_once", int'(cmd_drop), 0);
    repeat (10) begin
      @(negedge clk);
      if (dac_valid) vcount++;
    end
    check_val("drop_no_valid", vcount, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int base;
    send_cmd(0, OP_ON, 8'd0);
    base  = m_tgt;
    sb_on = 1'b0;
    req_valid  = 3'b111;
    req_op     = {OP_INC, OP_INC, OP_INC};
    req_amount = {8'd1, 8'd1, 8'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("rr_grant", int'(req_ready), 1 << m_ptr);
      check_val("rr_target", int'(target), base + 16 * k);
      m_ptr = (m_ptr + 1) % 3;
      @(posedge clk);
      #1;
    end
    req_valid = 3'b000;
    m_tgt = base + 96;
    check_val("rr_final", int'(target), m_tgt);
    wait_idle("rr", 100);
    m_lvl = m_tgt;
    sb_on = 1'b1;
    check_val("rr_level", int'(level), m_lvl);
  endtask

  task automatic test_off_priority();
    req_valid             = 3'b101;
    req_op[1:0]           = OP_INC;
    req_amount[7:0]       = 8'd1;
    req_op[5:4]           = OP_OFF;
    req_amount[23:16]     = 8'd0;
    @(negedge clk);
    check_val("offp_grant", int'(req_ready), 3'b100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    m_tgt = 0;
    expect_emerg();
    check_val("offp_enabled", int'(enabled), 0);
    check_val("offp_target", int'(target), 0);
    @(negedge clk);
    check_val("offp_next_grant", int'(req_ready), 3'b001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    m_ptr = 1;
    check_val("offp_drop", int'(cmd_drop), 1);
    @(negedge clk);
    check_val("offp_emerg_valid", int'(dac_valid), 1);
    check_val("offp_emerg_data", int'(dac_data), 0);
    @(posedge clk);
    #1;
    wait_idle("offp", 20);
    check_val("offp_level", int'(level), 0);
  endtask

  task automatic test_reset_mid_send();
    int c = 0;
    int vcount = 0;
    send_cmd(0, OP_ON, 8'd0);
    dac_ready = 1'b0;
    send_cmd(0, OP_INC, 8'd4);
    check_val("mid_target", int'(target), 64);
    @(negedge clk);
    while (!dac_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_val("mid_valid", int'(dac_valid), 1);
    check_val("mid_data", int'(dac_data), 64);
    repeat (3) @(negedge clk);
    check_val("mid_hold", int'(dac_data), 64);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", int'(dac_valid), 0);
    check_val("arst_data", int'(dac_data), 0);
    check_val("arst_enabled", int'(enabled), 0);
    check_val("arst_target", int'(target), 0);
    check_val("arst_level", int'(level), 0);
    check_val("arst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    dac_ready = 1'b1;
    m_ptr = 0; m_tgt = 0; m_lvl = 0;
    repeat (20) begin
      @(negedge clk);
      if (dac_valid) vcount++;
    end
    check_val("arst_no_stale", vcount, 0);
    check_val("arst_level_after", int'(level), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_amount = '0;
    dac_ready  = 1'b1;
    test_reset();
    test_ramp();
    test_saturate();
    test_disabled_drop();
    test_round_robin();
    test_off_priority();
    test_reset_mid_send();
    check_val("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
